// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO controller and its per-pin debounce cells.
package gpio_pkg;

  localparam int GPIO_WIDTH            = 16;
  localparam int GPIO_DEBOUNCE_DEFAULT = 4;
  // Position of the GPIO line within the core's ext_interrupts vector.
  localparam int GPIO_EXT_IRQ_BIT      = 0;

  // Counter width able to hold every value up to the debounce length.
  function automatic int debounce_cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One GPIO input: 2-flop synchroniser, persistence counter, accepted level
// and a single-cycle change pulse aligned with the edge that accepts it.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_in,
  output logic stable,
  output logic chg
);

  localparam int               CNT_W    = debounce_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_reg;
  logic             s_reg;
  logic             stable_reg;
  logic             stable_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Bring the asynchronous pad level into the clock domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg <= 1'b0;
      s_reg     <= 1'b0;
    end else begin
      sync1_reg <= pin_in;
      s_reg     <= sync1_reg;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES edges;
  // chg is combinational so pending logic registers it on the accepting edge.
  always_comb begin
    cnt_next    = cnt_reg;
    stable_next = stable_reg;
    chg         = 1'b0;
    if (s_reg == stable_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_LAST) begin
      stable_next = s_reg;
      cnt_next    = '0;
      chg         = 1'b1;
    end else begin
      cnt_next = cnt_reg + CNT_ONE;
    end
  end

  // Counter and accepted-level registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      stable_reg <= stable_next;
    end
  end

  assign stable = stable_reg;

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO pin controller: registered pad drive, debounced pin readback and
// latched, maskable change interrupts feeding one core interrupt line.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH           = GPIO_WIDTH,
  parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  input  logic [WIDTH-1:0] rf_gpio_datareg,
  input  logic [WIDTH-1:0] rf_gpio_tristate,
  input  logic [WIDTH-1:0] rf_gpio_interrupt_mask,
  input  logic [WIDTH-1:0] irq_clear,
  output logic [WIDTH-1:0] ro_gpio_pinstate,
  output logic [WIDTH-1:0] irq_pending,
  output logic             ext_irq
);

  logic [WIDTH-1:0] pin_out_reg;
  logic [WIDTH-1:0] pin_oe_reg;
  logic [WIDTH-1:0] stable_vec;
  logic [WIDTH-1:0] chg_vec;
  logic [WIDTH-1:0] pending_reg;
  logic [WIDTH-1:0] pending_next;

  // Every pin is debounced, outputs included, so loopback reads the drive.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
      gpio_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .pin_in (pin_in[gi]),
        .stable (stable_vec[gi]),
        .chg    (chg_vec[gi])
      );
    end
  endgenerate

  // Pad drive registers; reset leaves every pin hi-Z.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pin_out_reg <= '0;
      pin_oe_reg  <= '0;
    end else begin
      pin_out_reg <= rf_gpio_datareg;
      pin_oe_reg  <= ~rf_gpio_tristate;
    end
  end

  // Set wins over clear; only input pins enabled at the change can set.
  always_comb begin
    pending_next = (pending_reg & ~irq_clear)
                 | (chg_vec & rf_gpio_interrupt_mask & rf_gpio_tristate);
  end

  // Pending flags persist through later mask changes until cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  assign pin_out          = pin_out_reg;
  assign pin_oe           = pin_oe_reg;
  assign ro_gpio_pinstate = stable_vec;
  assign irq_pending      = pending_reg;
  assign ext_irq          = |(pending_reg & rf_gpio_interrupt_mask);

endmodule

// File: tb/tb_gpio_ctrl.sv
// Bench for gpio_ctrl: directed steps plus a randomized phase, compared
// against a sliding-window behavioural model of debounce and interrupts.
module tb_gpio_ctrl;

  localparam int W = 16;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] pin_in;
  logic [W-1:0] pin_out;
  logic [W-1:0] pin_oe;
  logic [W-1:0] rf_gpio_datareg;
  logic [W-1:0] rf_gpio_tristate;
  logic [W-1:0] rf_gpio_interrupt_mask;
  logic [W-1:0] irq_clear;
  logic [W-1:0] ro_gpio_pinstate;
  logic [W-1:0] irq_pending;
  logic         ext_irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio_ctrl #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .pin_in                 (pin_in),
    .pin_out                (pin_out),
    .pin_oe                 (pin_oe),
    .rf_gpio_datareg        (rf_gpio_datareg),
    .rf_gpio_tristate       (rf_gpio_tristate),
    .rf_gpio_interrupt_mask (rf_gpio_interrupt_mask),
    .irq_clear              (irq_clear),
    .ro_gpio_pinstate       (ro_gpio_pinstate),
    .irq_pending            (irq_pending),
    .ext_irq                (ext_irq)
  );

  // Reference model: m_hist[0] is the pad sample from the previous edge,
  // m_hist[j] the one from j edges earlier. The synchronised level seen at an
  // edge is m_hist[1]; a level is accepted once the last D synchronised
  // samples all equal it and it differs from the accepted level.
  logic [W-1:0] m_hist [0:D];
  logic [W-1:0] m_stable;
  logic [W-1:0] m_pend;
  logic [W-1:0] m_out;
  logic [W-1:0] m_oe;

  function automatic logic [W-1:0] model_chg();
    logic [W-1:0] all_hi;
    logic [W-1:0] all_lo;
    all_hi = '1;
    all_lo = '1;
    for (int j = 1; j <= D; j++) begin
      all_hi &= m_hist[j];
      all_lo &= ~m_hist[j];
    end
    return (all_hi & ~m_stable) | (all_lo & m_stable);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j <= D; j++) m_hist[j] <= '0;
      m_stable <= '0;
      m_pend   <= '0;
      m_out    <= '0;
      m_oe     <= '0;
    end else begin
      m_hist[0] <= pin_in;
      for (int j = 1; j <= D; j++) m_hist[j] <= m_hist[j-1];
      m_stable <= m_stable ^ model_chg();
      m_pend   <= (m_pend & ~irq_clear)
                | (model_chg() & rf_gpio_interrupt_mask & rf_gpio_tristate);
      m_out    <= rf_gpio_datareg;
      m_oe     <= ~rf_gpio_tristate;
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("model_pin_out", pin_out, m_out);
    chk("model_pin_oe", pin_oe, m_oe);
    chk("model_pinstate", ro_gpio_pinstate, m_stable);
    chk("model_pending", irq_pending, m_pend);
    chk_bit("model_ext_irq", ext_irq, |(m_pend & rf_gpio_interrupt_mask));
  endtask

  // Advance past one rising edge and compare against the model mid-cycle.
  task automatic tick();
    @(negedge clk);
    chk_model();
  endtask

  initial begin
    // Reset with random inputs
    reset                  = 1'b0;
    pin_in                 = W'($urandom);
    rf_gpio_datareg        = W'($urandom);
    rf_gpio_tristate       = W'($urandom);
    rf_gpio_interrupt_mask = W'($urandom);
    irq_clear              = W'($urandom);
    repeat (3) tick();
    chk("rst_pin_out", pin_out, 16'h0000);
    chk("rst_pin_oe", pin_oe, 16'h0000);
    chk("rst_pinstate", ro_gpio_pinstate, 16'h0000);
    chk("rst_pending", irq_pending, 16'h0000);
    chk_bit("rst_ext_irq", ext_irq, 1'b0);

    pin_in                 = '0;
    rf_gpio_datareg        = '0;
    rf_gpio_tristate       = '1;
    rf_gpio_interrupt_mask = '1;
    irq_clear              = '0;
    reset                  = 1'b1;
    repeat (8) tick();
    chk_bit("post_rst_ext_irq", ext_irq, 1'b0);
    $display("step reset: checks=%0d errors=%0d", checks, errors);

    // Output drive
    rf_gpio_tristate = 16'hFF00;
    rf_gpio_datareg  = 16'h00A5;
    tick();
    chk("drive_pin_oe", pin_oe, 16'h00FF);
    chk("drive_pin_out", pin_out, 16'h00A5);
    $display("step drive: pin_oe=%h pin_out=%h", pin_oe, pin_out);

    // Debounced interrupt on pin 0, then clear
    rf_gpio_tristate       = 16'hFFFF;
    rf_gpio_interrupt_mask = 16'h0001;
    pin_in                 = 16'h0001;
    repeat (5) tick();
    chk("deb_early_pinstate", ro_gpio_pinstate, 16'h0000);
    chk("deb_early_pending", irq_pending, 16'h0000);
    chk_bit("deb_early_ext", ext_irq, 1'b0);
    tick();
    chk("deb_pinstate", ro_gpio_pinstate, 16'h0001);
    chk("deb_pending", irq_pending, 16'h0001);
    chk_bit("deb_ext", ext_irq, 1'b1);
    irq_clear = 16'h0001;
    tick();
    irq_clear = '0;
    chk("clr_pending", irq_pending, 16'h0000);
    chk_bit("clr_ext", ext_irq, 1'b0);
    $display("step debounce: pinstate=%h pending=%h", ro_gpio_pinstate, irq_pending);

    // Glitch rejection on pin 3, then a long enough pulse
    rf_gpio_interrupt_mask = 16'h0009;
    pin_in = 16'h0009;
    repeat (3) tick();
    pin_in = 16'h0001;
    repeat (8) tick();
    chk("glitch_pinstate", ro_gpio_pinstate, 16'h0001);
    chk("glitch_pending", irq_pending, 16'h0000);
    chk_bit("glitch_ext", ext_irq, 1'b0);
    pin_in = 16'h0009;
    repeat (4) tick();
    pin_in = 16'h0001;
    repeat (2) tick();
    chk("pulse4_pinstate", ro_gpio_pinstate, 16'h0009);
    chk("pulse4_pending", irq_pending, 16'h0008);
    chk_bit("pulse4_ext", ext_irq, 1'b1);
    repeat (4) tick();
    chk("pulse4_fall_pinstate", ro_gpio_pinstate, 16'h0001);
    irq_clear = '1;
    tick();
    irq_clear = '0;
    chk("pulse4_clr", irq_pending, 16'h0000);
    $display("step glitch: pinstate=%h pending=%h", ro_gpio_pinstate, irq_pending);

    // Masked pin 5, output pin 8, mask removed after the fact on pin 2
    rf_gpio_interrupt_mask = 16'hFFDF;
    pin_in = 16'h0021;
    repeat (6) tick();
    chk("masked_pinstate", ro_gpio_pinstate, 16'h0021);
    chk("masked_pending", irq_pending, 16'h0000);
    rf_gpio_tristate       = 16'hFEFF;
    rf_gpio_interrupt_mask = 16'hFFFF;
    pin_in = 16'h0121;
    repeat (6) tick();
    chk("outpin_pinstate", ro_gpio_pinstate, 16'h0121);
    chk("outpin_pending", irq_pending, 16'h0000);
    chk_bit("outpin_ext", ext_irq, 1'b0);
    rf_gpio_tristate       = 16'hFFFF;
    rf_gpio_interrupt_mask = 16'h0004;
    pin_in = 16'h0125;
    repeat (6) tick();
    chk("pin2_pending", irq_pending, 16'h0004);
    chk_bit("pin2_ext", ext_irq, 1'b1);
    rf_gpio_interrupt_mask = 16'h0000;
    #1;
    chk_bit("unmask_ext", ext_irq, 1'b0);
    chk("unmask_pending", irq_pending, 16'h0004);
    rf_gpio_interrupt_mask = 16'h0004;
    #1;
    chk_bit("remask_ext", ext_irq, 1'b1);
    $display("step mask: pinstate=%h pending=%h", ro_gpio_pinstate, irq_pending);

    // Set and clear on the same edge: set wins
    irq_clear = '1;
    tick();
    irq_clear = '0;
    rf_gpio_interrupt_mask = 16'h0001;
    pin_in = 16'h0124;
    repeat (6) tick();
    chk("fall0_pending", irq_pending, 16'h0001);
    pin_in = 16'h0125;
    repeat (5) tick();
    irq_clear = 16'h0001;
    tick();
    irq_clear = '0;
    chk("setclr_pending", irq_pending, 16'h0001);
    chk("setclr_pinstate", ro_gpio_pinstate, 16'h0125);
    $display("step setclr: pending=%h", irq_pending);

    // Reset in the middle of a debounce on pin 7
    pin_in = 16'h01A5;
    repeat (4) tick();
    reset = 1'b0;
    #1;
    chk("midrst_pin_out", pin_out, 16'h0000);
    chk("midrst_pin_oe", pin_oe, 16'h0000);
    chk("midrst_pinstate", ro_gpio_pinstate, 16'h0000);
    chk("midrst_pending", irq_pending, 16'h0000);
    chk_bit("midrst_ext", ext_irq, 1'b0);

    // Release with pin 1 already high: seen as an ordinary rising change
    pin_in                 = 16'h0002;
    rf_gpio_interrupt_mask = 16'h0002;
    rf_gpio_tristate       = 16'hFFFF;
    irq_clear              = '0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (6) tick();
    chk("relhigh_pending", irq_pending, 16'h0002);
    chk("relhigh_pinstate", ro_gpio_pinstate, 16'h0002);
    chk_bit("relhigh_ext", ext_irq, 1'b1);
    $display("step release-high: pending=%h", irq_pending);

    // Randomized phase against the model
    for (int i = 0; i < 600; i++) begin
      pin_in = pin_in ^ W'($urandom & $urandom & $urandom);
      rf_gpio_datareg = W'($urandom);
      if ($urandom_range(0, 15) == 0) rf_gpio_interrupt_mask = W'($urandom);
      if ($urandom_range(0, 15) == 0) rf_gpio_tristate = W'($urandom);
      irq_clear = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      if (i == 300) reset = 1'b0;
      if (i == 302) reset = 1'b1;
      tick();
    end
    $display("step random: checks=%0d errors=%0d", checks, errors);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
